// File: rtl/pll_seq_ctrl.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable lock, releases the
// downstream reset, retries on timeout and applies divider reconfiguration requests.
module pll_seq_ctrl #(
    parameter int unsigned RST_CYC    = 27,
    parameter int unsigned LOCK_TMO   = 270000,
    parameter int unsigned STABLE_CYC = 1024,
    parameter int unsigned MAX_RETRY  = 3,
    parameter logic [5:0]  DEF_IDSEL  = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL = 6'd0,
    parameter logic [5:0]  DEF_ODSEL  = 6'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [7:0] lost_cnt
);

    localparam int unsigned MAX_A   = (RST_CYC > LOCK_TMO) ? RST_CYC : LOCK_TMO;
    localparam int unsigned MAX_CYC = (MAX_A > STABLE_CYC) ? MAX_A : STABLE_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned LOST_W  = 8;

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'((RST_CYC > 0) ? RST_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'((LOCK_TMO > 0) ? LOCK_TMO - 1 : 0);
    // The lk=1 cycle seen in WAIT_LOCK counts as the first stable cycle.
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'((STABLE_CYC >= 2) ? STABLE_CYC - 2 : 0);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [LOST_W-1:0]  LOST_SAT  = {LOST_W{1'b1}};

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_nxt_cnt;
    logic [RETRY_W-1:0]  r_retry;
    logic [RETRY_W-1:0]  w_nxt_retry;
    logic [LOST_W-1:0]   r_lost;
    logic [LOST_W-1:0]   w_nxt_lost;
    logic                w_accept;

    logic                r_lk_meta;
    logic                r_lk;
    logic                r_pll_reset;
    logic                r_sys_rst_n;
    logic                r_ready;
    logic                r_fail;
    logic                r_cfg_ack;
    logic [5:0]          r_idsel;
    logic [5:0]          r_fbdsel;
    logic [5:0]          r_odsel;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= pll_lock;
            r_lk      <= r_lk_meta;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_retry = r_retry;
        w_nxt_lost  = r_lost;
        w_accept    = 1'b0;

        case (r_state)
            S_RST: begin
                if (r_cnt >= RST_LAST) begin
                    w_nxt_state = S_WAIT_LOCK;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (r_lk) begin
                    w_nxt_state = S_STABLE;
                    w_nxt_cnt   = '0;
                end else if (r_cnt >= TMO_LAST) begin
                    w_nxt_cnt = '0;
                    if (r_retry < RETRY_MAX) begin
                        w_nxt_retry = r_retry + RETRY_W'(1);
                        w_nxt_state = S_RST;
                    end else begin
                        w_nxt_state = S_FAIL;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!r_lk) begin
                    w_nxt_state = S_WAIT_LOCK;
                    w_nxt_cnt   = '0;
                end else if (r_cnt >= STB_LAST) begin
                    w_nxt_state = S_RUN;
                    w_nxt_cnt   = '0;
                    w_nxt_retry = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                // A config request and a lock loss in the same cycle are both honoured
                if (cfg_req) begin
                    w_accept    = 1'b1;
                    w_nxt_retry = '0;
                    w_nxt_state = S_RST;
                    w_nxt_cnt   = '0;
                end
                if (!r_lk) begin
                    w_nxt_lost  = (r_lost == LOST_SAT) ? r_lost : r_lost + LOST_W'(1);
                    w_nxt_state = S_RST;
                    w_nxt_cnt   = '0;
                end
            end
            S_FAIL: begin
                if (cfg_req) begin
                    w_accept    = 1'b1;
                    w_nxt_retry = '0;
                    w_nxt_state = S_RST;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = S_RST;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_RST;
            r_cnt   <= '0;
            r_retry <= '0;
            r_lost  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_retry <= w_nxt_retry;
            r_lost  <= w_nxt_lost;
        end
    end

    // Outputs registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_cfg_ack   <= 1'b0;
            r_idsel     <= DEF_IDSEL;
            r_fbdsel    <= DEF_FBDSEL;
            r_odsel     <= DEF_ODSEL;
        end else begin
            r_pll_reset <= (w_nxt_state == S_RST) || (w_nxt_state == S_FAIL);
            r_sys_rst_n <= (w_nxt_state == S_RUN);
            r_ready     <= (w_nxt_state == S_RUN);
            r_fail      <= (w_nxt_state == S_FAIL);
            r_cfg_ack   <= w_accept;
            if (w_accept) begin
                r_idsel  <= cfg_idsel;
                r_fbdsel <= cfg_fbdsel;
                r_odsel  <= cfg_odsel;
            end
        end
    end

    assign pll_reset  = r_pll_reset;
    assign sys_rst_n  = r_sys_rst_n;
    assign ready      = r_ready;
    assign fail       = r_fail;
    assign cfg_ack    = r_cfg_ack;
    assign lost_cnt   = r_lost;
    assign pll_idsel  = r_idsel;
    assign pll_fbdsel = r_fbdsel;
    assign pll_odsel  = r_odsel;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl: bring-up, lock loss, reconfiguration,
// STABLE glitch, retry/FAIL handling and asynchronous reset abort.
`timescale 1ns/1ps
module tb_pll_seq_ctrl;

    localparam int unsigned RST_CYC    = 4;
    localparam int unsigned LOCK_TMO   = 20;
    localparam int unsigned STABLE_CYC = 8;
    localparam int unsigned MAX_RETRY  = 2;
    localparam logic [5:0]  DEF_I      = 6'h01;
    localparam logic [5:0]  DEF_FB     = 6'h02;
    localparam logic [5:0]  DEF_O      = 6'h03;

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       cfg_req;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic       cfg_ack;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] lost_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pll_seq_ctrl #(
        .RST_CYC    (RST_CYC),
        .LOCK_TMO   (LOCK_TMO),
        .STABLE_CYC (STABLE_CYC),
        .MAX_RETRY  (MAX_RETRY),
        .DEF_IDSEL  (DEF_I),
        .DEF_FBDSEL (DEF_FB),
        .DEF_ODSEL  (DEF_O)
    ) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .cfg_req    (cfg_req),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .cfg_ack    (cfg_ack),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .lost_cnt   (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return pll_reset;
            1:       return ready;
            2:       return sys_rst_n;
            default: return fail;
        endcase
    endfunction

    // Bounded wait for a selected output to reach a level; n = cycles waited
    task automatic wait_for(input int which, input logic val, input int bound,
                            input string tag, output int n);
        n = 0;
        while (sig(which) !== val && n < bound) begin
            tick(1);
            n++;
        end
        check(tag, 32'(sig(which)), 32'(val));
    endtask

    task automatic falls_until_fail(input int bound, output int falls);
        logic prev;
        int   n;
        prev  = pll_reset;
        n     = 0;
        falls = 0;
        while (!fail && n < bound) begin
            tick(1);
            n++;
            if (prev && !pll_reset) falls++;
            prev = pll_reset;
        end
        check("fail_reached", 32'(fail), 32'd1);
    endtask

    initial begin
        int n;
        int acks;
        int falls;

        resetn     = 1'b0;
        pll_lock   = 1'b0;
        cfg_req    = 1'b0;
        cfg_idsel  = 6'h00;
        cfg_fbdsel = 6'h00;
        cfg_odsel  = 6'h00;
        tick(3);

        // Reset values
        check("rst_pll_reset", 32'(pll_reset), 32'd1);
        check("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("rst_ready",     32'(ready),     32'd0);
        check("rst_fail",      32'(fail),      32'd0);
        check("rst_cfg_ack",   32'(cfg_ack),   32'd0);
        check("rst_lost",      32'(lost_cnt),  32'd0);
        check("rst_idsel",     32'(pll_idsel), 32'(DEF_I));
        check("rst_fbdsel",    32'(pll_fbdsel),32'(DEF_FB));
        check("rst_odsel",     32'(pll_odsel), 32'(DEF_O));

        // Nominal bring-up
        resetn = 1'b1;
        wait_for(0, 1'b0, 20, "bringup_rst_fall", n);
        check("bringup_rst_width", n, RST_CYC);
        tick(5);
        pll_lock = 1'b1;
        wait_for(1, 1'b1, 40, "bringup_ready", n);
        check("bringup_lock_to_ready", n, 2 + STABLE_CYC);
        check("bringup_sys_rst_n", 32'(sys_rst_n), 32'd1);
        check("bringup_pll_reset", 32'(pll_reset), 32'd0);

        // Lock loss in RUN
        pll_lock = 1'b0;
        tick(2);
        check("loss_still_run", 32'(sys_rst_n), 32'd1);
        tick(1);
        check("loss_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("loss_lost_cnt",  32'(lost_cnt),  32'd1);
        check("loss_pll_reset", 32'(pll_reset), 32'd1);
        check("loss_ready",     32'(ready),     32'd0);
        wait_for(0, 1'b0, 20, "loss_rst_fall", n);
        check("loss_rst_width", n, RST_CYC);
        pll_lock = 1'b1;
        wait_for(1, 1'b1, 40, "loss_relock", n);
        check("loss_relock_cycles", n, 2 + STABLE_CYC);

        // Config request held through WAIT_LOCK/STABLE, accepted in RUN
        pll_lock = 1'b0;
        wait_for(0, 1'b1, 10, "cfg_a_rst", n);
        wait_for(0, 1'b0, 10, "cfg_a_wait", n);
        cfg_idsel  = 6'h11;
        cfg_fbdsel = 6'h22;
        cfg_odsel  = 6'h33;
        cfg_req    = 1'b1;
        tick(3);
        pll_lock = 1'b1;
        acks = (cfg_ack) ? 1 : 0;
        n = 0;
        while (!ready && n < 60) begin
            tick(1);
            n++;
            if (cfg_ack) acks++;
        end
        check("cfg_a_no_early_ack", acks, 0);
        check("cfg_a_reached_run", 32'(ready), 32'd1);
        check("cfg_a_sel_unchanged", 32'(pll_idsel), 32'(DEF_I));
        tick(1);
        check("cfg_a_ack",       32'(cfg_ack),    32'd1);
        check("cfg_a_idsel",     32'(pll_idsel),  32'h11);
        check("cfg_a_fbdsel",    32'(pll_fbdsel), 32'h22);
        check("cfg_a_odsel",     32'(pll_odsel),  32'h33);
        check("cfg_a_pll_reset", 32'(pll_reset),  32'd1);
        check("cfg_a_ready",     32'(ready),      32'd0);
        cfg_req = 1'b0;
        tick(1);
        check("cfg_a_ack_pulse", 32'(cfg_ack), 32'd0);
        wait_for(1, 1'b1, 40, "cfg_a_relock", n);
        check("cfg_a_lost", 32'(lost_cnt), 32'd2);

        // Config request coinciding with a lock drop in RUN
        pll_lock = 1'b0;
        tick(2);
        check("cfg_b_still_run", 32'(ready), 32'd1);
        cfg_idsel  = 6'h05;
        cfg_fbdsel = 6'h06;
        cfg_odsel  = 6'h07;
        cfg_req    = 1'b1;
        tick(1);
        check("cfg_b_ack",       32'(cfg_ack),   32'd1);
        check("cfg_b_lost",      32'(lost_cnt),  32'd3);
        check("cfg_b_idsel",     32'(pll_idsel), 32'h05);
        check("cfg_b_odsel",     32'(pll_odsel), 32'h07);
        check("cfg_b_sys_rst_n", 32'(sys_rst_n), 32'd0);
        cfg_req  = 1'b0;
        pll_lock = 1'b1;
        wait_for(1, 1'b1, 40, "cfg_b_relock", n);

        // Repeated losses saturate the counter
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            wait_for(2, 1'b0, 10, "sat_loss", n);
            pll_lock = 1'b1;
            wait_for(1, 1'b1, 40, "sat_relock", n);
            if (i == 99) check("sat_lost_mid", 32'(lost_cnt), 32'd103);
        end
        check("sat_lost_final", 32'(lost_cnt), 32'd255);

        // Lock glitch during STABLE restarts the stability window
        pll_lock = 1'b0;
        wait_for(0, 1'b1, 10, "glitch_rst", n);
        wait_for(0, 1'b0, 10, "glitch_wait", n);
        pll_lock = 1'b1;
        tick(5);
        check("glitch_not_ready", 32'(ready), 32'd0);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        wait_for(1, 1'b1, 40, "glitch_ready", n);
        check("glitch_relock_cycles", n, 2 + STABLE_CYC);

        // Glitch after one timeout keeps the retry count: only one more pulse before FAIL
        pll_lock = 1'b0;
        wait_for(0, 1'b1, 10, "retry_rst0", n);
        wait_for(0, 1'b0, 10, "retry_wait0", n);
        wait_for(0, 1'b1, 30, "retry_tmo1", n);
        check("retry_tmo_cycles", n, LOCK_TMO);
        wait_for(0, 1'b0, 10, "retry_wait1", n);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        falls_until_fail(200, falls);
        check("retry_kept_pulses", falls, 1);
        check("retry_fail_sys_rst_n", 32'(sys_rst_n), 32'd0);
        cfg_idsel  = 6'h2a;
        cfg_fbdsel = 6'h15;
        cfg_odsel  = 6'h3f;
        cfg_req    = 1'b1;
        tick(1);
        check("retry_exit_ack",   32'(cfg_ack),   32'd1);
        check("retry_exit_idsel", 32'(pll_idsel), 32'h2a);
        check("retry_exit_fail",  32'(fail),      32'd0);
        cfg_req = 1'b0;

        // Asynchronous reset in the middle of STABLE
        wait_for(0, 1'b0, 10, "ares_wait", n);
        pll_lock = 1'b1;
        tick(5);
        check("ares_in_stable", 32'(ready), 32'd0);
        resetn = 1'b0;
        #1;
        check("ares_pll_reset", 32'(pll_reset),  32'd1);
        check("ares_sys_rst_n", 32'(sys_rst_n),  32'd0);
        check("ares_ready",     32'(ready),      32'd0);
        check("ares_fail",      32'(fail),       32'd0);
        check("ares_cfg_ack",   32'(cfg_ack),    32'd0);
        check("ares_lost",      32'(lost_cnt),   32'd0);
        check("ares_idsel",     32'(pll_idsel),  32'(DEF_I));
        check("ares_fbdsel",    32'(pll_fbdsel), 32'(DEF_FB));
        check("ares_odsel",     32'(pll_odsel),  32'(DEF_O));
        pll_lock = 1'b0;
        tick(3);
        resetn = 1'b1;
        wait_for(0, 1'b0, 20, "ares_rst_fall", n);
        check("ares_rst_width", n, RST_CYC);

        // Lock never arrives: three reset pulses in total, then FAIL
        falls_until_fail(400, falls);
        check("tmo_pulses", falls + 1, MAX_RETRY + 1);
        check("tmo_pll_reset", 32'(pll_reset), 32'd1);
        check("tmo_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("tmo_ready",     32'(ready),     32'd0);
        cfg_idsel  = DEF_I;
        cfg_fbdsel = DEF_FB;
        cfg_odsel  = 6'h08;
        cfg_req    = 1'b1;
        tick(1);
        check("tmo_exit_ack",       32'(cfg_ack),   32'd1);
        check("tmo_exit_odsel",     32'(pll_odsel), 32'h08);
        check("tmo_exit_fail",      32'(fail),      32'd0);
        check("tmo_exit_pll_reset", 32'(pll_reset), 32'd1);
        cfg_req = 1'b0;
        tick(1);
        check("tmo_exit_ack_pulse", 32'(cfg_ack), 32'd0);
        wait_for(0, 1'b0, 10, "tmo_exit_rst_fall", n);
        check("tmo_exit_rst_width", n + 1, RST_CYC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_seq_ctrl.md
PLL_SEQ_CTRL -- requirements
Module: pll_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- RST_CYC, 27: pll_reset pulse width in clk cycles.
- LOCK_TMO, 270000: cycles to wait for lock before a retry (10 ms at 27 MHz).
- STABLE_CYC, 1024: consecutive locked cycles required before release.
- MAX_RETRY, 3: lock timeouts tolerated before entering FAIL.
- DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL, 6'd0: power-on divider selects.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1: 27 MHz reference clock, the same net that feeds the PLL clkin.
- resetn, in, 1: reset, asynchronous and active-low.
- pll_lock, in, 1: PLL LOCK output, asynchronous to clk.
- pll_reset, out, 1: drives the PLL RESET input, active-high.
- pll_idsel, pll_fbdsel, pll_odsel, out, 6 each: dynamic divider selects driven to the PLL.
- cfg_req, in, 1: request to apply a new divider configuration.
- cfg_idsel, cfg_fbdsel, cfg_odsel, in, 6 each: requested divider selects.
- cfg_ack, out, 1: single-cycle acceptance pulse.
- sys_rst_n, out, 1: downstream reset, active-low.
- ready, out, 1: high in RUN.
- fail, out, 1: high in FAIL.
- lost_cnt, out, 8: count of lock-loss events in RUN.

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value (lk), giving 2 cycles of input latency.
REQ-004 The FSM SHALL have five states: RST, WAIT_LOCK, STABLE, RUN, FAIL.
REQ-005 In RST:
- pll_reset=1 for exactly RST_CYC cycles.
- Then go to WAIT_LOCK with the counter cleared.
REQ-006 In WAIT_LOCK:
- pll_reset=0 and the counter increments each cycle.
- If lk=1, go to STABLE with the counter cleared.
- If the counter reaches LOCK_TMO-1 with lk=0 and retry<MAX_RETRY, increment retry and go to RST.
- If the counter reaches LOCK_TMO-1 with lk=0 and retry==MAX_RETRY, go to FAIL.
REQ-007 In STABLE:
- The counter increments while lk=1.
- If lk=0, go to WAIT_LOCK with the counter cleared; retry SHALL be unchanged.
- After STABLE_CYC consecutive lk=1 cycles, go to RUN and clear retry.
REQ-008 In RUN:
- sys_rst_n=1 and ready=1.
- If lk=0, increment lost_cnt (saturating at 255), go to RST, and assert sys_rst_n=0 in that same transition cycle.
REQ-009 In FAIL:
- fail=1, pll_reset=1, sys_rst_n=0.
- Remain in FAIL until a cfg_req is accepted.
REQ-010 sys_rst_n SHALL be 0 in every state except RUN and SHALL be a registered output.
REQ-011 cfg_req handshake:
- cfg_req is level-sensitive and is accepted only in RUN or FAIL.
- On acceptance: cfg_ack=1 for one cycle, cfg_* are latched into pll_*sel, retry clears, and the FSM goes to RST.
- In any other state cfg_req SHALL be held pending with no ack; the requester keeps cfg_req high until cfg_ack.
REQ-012 If cfg_req and lk=0 occur in the same RUN cycle, the config SHALL be accepted (ack, latch), and lost_cnt SHALL also increment.
REQ-013 pll_*sel SHALL change only on acceptance, so they are stable whenever pll_reset=0.
REQ-014 Counter width SHALL be ceil(log2(max(RST_CYC, LOCK_TMO, STABLE_CYC)+1)) bits, and the counter SHALL never wrap.

Reset
REQ-015 While resetn=0, the block SHALL hold:
- FSM in RST with the counter at 0.
- pll_reset=1, sys_rst_n=0, ready=0, fail=0, cfg_ack=0.
- retry=0, lost_cnt=0.
- pll_*sel=DEF_*.
- Synchronizer flops at 0.
REQ-016 After resetn rises, the block SHALL run a full RST pulse of RST_CYC cycles.
REQ-017 An assertion of resetn in any state SHALL abort immediately to the REQ-015 values.

Verification
Bench parameters: RST_CYC=4, LOCK_TMO=20, STABLE_CYC=8, MAX_RETRY=2.
REQ-018 Nominal bring-up SHALL be tested: resetn rises; pll_lock rises 5 cycles after pll_reset falls -> pll_reset high 4 cycles; ready and sys_rst_n go to 1 exactly 2+8 cycles after the pll_lock edge.
REQ-019 Timeout and FAIL SHALL be tested: pll_lock held 0 -> 3 RST pulses, then fail=1, pll_reset=1, sys_rst_n=0; then cfg_req with cfg_odsel=6'h08 -> cfg_ack one cycle, pll_odsel=6'h08, fail=0, a new RST pulse.
REQ-020 The STABLE glitch SHALL be tested: lock high 5 cycles, low 1 cycle, then high -> return to WAIT_LOCK, retry unchanged, ready only after 8 new consecutive cycles.
REQ-021 Lock loss in RUN SHALL be tested: drop pll_lock -> sys_rst_n=0, lost_cnt=1, RST pulse, re-lock to RUN; 300 losses -> lost_cnt=255.
REQ-022 Reconfiguration SHALL be tested: cfg_req asserted during WAIT_LOCK -> no ack until RUN; in RUN -> ack pulse, pll_idsel/pll_fbdsel/pll_odsel equal the cfg values before pll_reset falls; simultaneous lock drop -> ack and lost_cnt incremented.
REQ-023 Asynchronous reset SHALL be tested: resetn pulled low mid-STABLE -> all outputs at reset values within the same cycle, pll_*sel=DEF_*.
